// File: rtl/cache_tag_if.sv
// cache_tag_if: request, response, flush and statistics signals of cache_tag_ctrl.
interface cache_tag_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic              flush_start;
   logic              flush_done;
   logic              resp_valid;
   logic              resp_hit;
   logic              resp_evict;
   logic              resp_wb;
   logic [ADDR_W-1:0] resp_wb_addr;
   logic [31:0]       stat_acc;
   logic [31:0]       stat_rd;
   logic [31:0]       stat_wr;
   logic [31:0]       stat_hit;
   logic [31:0]       stat_miss;
   logic [31:0]       stat_evict;
   logic [31:0]       stat_wb;
   modport master (
      output req_valid, req_rw, req_addr, flush_start,
      input  req_ready, flush_done, resp_valid, resp_hit, resp_evict, resp_wb, resp_wb_addr,
      input  stat_acc, stat_rd, stat_wr, stat_hit, stat_miss, stat_evict, stat_wb
   );
   modport slave (
      input  req_valid, req_rw, req_addr, flush_start,
      output req_ready, flush_done, resp_valid, resp_hit, resp_evict, resp_wb, resp_wb_addr,
      output stat_acc, stat_rd, stat_wr, stat_hit, stat_miss, stat_evict, stat_wb
   );
endinterface

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: N-way set-associative tag/state controller, true-LRU, write-back/allocate, flush engine.
// Define CACHE_STATS_EN to implement the saturating stat_* counters; otherwise they read as 0.
module cache_tag_ctrl #(
   parameter int SETS       = 1024,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 64,
   parameter int ADDR_W     = 32
) (
   input logic        clk,
   input logic        reset,
   cache_tag_if.slave  bus
);
   localparam int OFFSET_W = $clog2(LINE_BYTES);
   localparam int INDEX_W  = $clog2(SETS);
   localparam int WAY_W    = $clog2(WAYS);
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_W   = ADDR_W - OFFSET_W;
   localparam int FC_W     = INDEX_W + WAY_W;

   if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
      $fatal(1, "SETS must be a power of two >= 2");
   end
   if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
      $fatal(1, "WAYS must be a power of two >= 2");
   end
   if (LINE_BYTES < 4 || LINE_BYTES > 256 || (LINE_BYTES & (LINE_BYTES - 1)) != 0) begin : g_bad_line
      $fatal(1, "LINE_BYTES must be a power of two in 4..256");
   end
   if (TAG_W < 1) begin : g_bad_addr
      $fatal(1, "ADDR_W too small for SETS and LINE_BYTES");
   end

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP, FLUSH} state_t;

   state_t              state_q, state_d;
   logic                rw_q;
   logic [LINE_W-1:0]   line_q;
   logic                hit_q;
   logic [WAY_W-1:0]    way_q;
   logic [FC_W-1:0]     fcnt_q;

   logic [TAG_W-1:0]    tag_mem   [SETS][WAYS];
   logic                valid_mem [SETS][WAYS];
   logic                dirty_mem [SETS][WAYS];
   logic [WAY_W-1:0]    age_mem   [SETS][WAYS];

   logic [INDEX_W-1:0]  idx, f_set;
   logic [TAG_W-1:0]    tg;
   logic [WAY_W-1:0]    f_way, hit_way, vic_way, old_age;
   logic [WAYS-1:0]     match;
   logic                hit, f_last, f_wb, r_evict, r_wb;

   assign idx     = line_q[INDEX_W-1:0];
   assign tg      = line_q[LINE_W-1:INDEX_W];
   assign f_set   = fcnt_q[FC_W-1:WAY_W];
   assign f_way   = fcnt_q[WAY_W-1:0];
   assign f_last  = &fcnt_q;
   assign f_wb    = valid_mem[f_set][f_way] && dirty_mem[f_set][f_way];
   assign r_evict = !hit_q && valid_mem[idx][way_q];
   assign r_wb    = r_evict && dirty_mem[idx][way_q];
   assign old_age = age_mem[idx][way_q];
   assign hit     = |match;

   // Victim: lowest invalid way wins over the LRU way (age all ones).
   always_comb begin
      match   = '0;
      hit_way = '0;
      vic_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = valid_mem[idx][w] && tag_mem[idx][w] == tg;
         if (match[w]) hit_way = WAY_W'(w);
         if (age_mem[idx][w] == '1) vic_way = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_mem[idx][w]) vic_way = WAY_W'(w);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      bus.req_ready    = 1'b0;
      bus.resp_valid   = 1'b0;
      bus.resp_hit     = 1'b0;
      bus.resp_evict   = 1'b0;
      bus.resp_wb      = 1'b0;
      bus.resp_wb_addr = '0;
      bus.flush_done   = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            state_d = bus.flush_start ? FLUSH : bus.req_valid ? LOOKUP : IDLE;
         end
         LOOKUP: state_d = RESP;
         RESP: begin
            state_d = IDLE;
            bus.resp_valid   = 1'b1;
            bus.resp_hit     = hit_q;
            bus.resp_evict   = r_evict;
            bus.resp_wb      = r_wb;
            bus.resp_wb_addr = r_wb ? {tag_mem[idx][way_q], idx, OFFSET_W'(0)} : '0;
         end
         default: begin
            state_d = f_last ? IDLE : FLUSH;
            bus.resp_valid   = f_wb;
            bus.resp_wb      = f_wb;
            bus.resp_wb_addr = f_wb ? {tag_mem[f_set][f_way], f_set, OFFSET_W'(0)} : '0;
            bus.flush_done   = f_last;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rw_q   <= 1'b0;
         line_q <= '0;
         hit_q  <= 1'b0;
         way_q  <= '0;
         fcnt_q <= '0;
      end else begin
         if (state_q == IDLE && bus.req_valid && !bus.flush_start) begin
            rw_q   <= bus.req_rw;
            line_q <= bus.req_addr[ADDR_W-1:OFFSET_W];
         end
         if (state_q == LOOKUP) begin
            hit_q <= hit;
            way_q <= hit ? hit_way : vic_way;
         end
         fcnt_q <= state_q == FLUSH ? fcnt_q + 1'b1 : '0;
      end

   always_ff @(posedge clk)
      if (state_q == RESP && !hit_q) tag_mem[idx][way_q] <= tg;

   // Ages form a permutation per set: 0 is MRU, WAYS-1 is LRU.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
               valid_mem[s][w] <= 1'b0;
               dirty_mem[s][w] <= 1'b0;
               age_mem[s][w]   <= WAY_W'(w);
            end
      end else if (state_q == RESP) begin
         valid_mem[idx][way_q] <= 1'b1;
         dirty_mem[idx][way_q] <= hit_q ? (dirty_mem[idx][way_q] | rw_q) : rw_q;
         for (int w = 0; w < WAYS; w++)
            age_mem[idx][w] <= WAY_W'(w) == way_q ? '0 :
                               age_mem[idx][w] < old_age ? age_mem[idx][w] + 1'b1 : age_mem[idx][w];
      end else if (state_q == FLUSH) begin
         valid_mem[f_set][f_way] <= 1'b0;
         dirty_mem[f_set][f_way] <= 1'b0;
      end

   a_single_hit: assert property (@(posedge clk) disable iff (reset) state_q == LOOKUP |-> $onehot0(match));

`ifdef CACHE_STATS_EN
   logic [31:0] acc_q, rd_q, wr_q, hit_cnt_q, miss_q, evict_q, wb_q;
   logic        rs, fs;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != '1) ? v + 32'd1 : v;
   endfunction

   assign rs = state_q == RESP;
   assign fs = state_q == FLUSH;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         acc_q     <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         hit_cnt_q <= '0;
         miss_q    <= '0;
         evict_q   <= '0;
         wb_q      <= '0;
      end else begin
         acc_q     <= sat_inc(acc_q, rs);
         rd_q      <= sat_inc(rd_q, rs && !rw_q);
         wr_q      <= sat_inc(wr_q, rs && rw_q);
         hit_cnt_q <= sat_inc(hit_cnt_q, rs && hit_q);
         miss_q    <= sat_inc(miss_q, rs && !hit_q);
         evict_q   <= sat_inc(evict_q, rs && r_evict);
         wb_q      <= sat_inc(wb_q, (rs && r_wb) || (fs && f_wb));
      end

   assign bus.stat_acc   = acc_q;
   assign bus.stat_rd    = rd_q;
   assign bus.stat_wr    = wr_q;
   assign bus.stat_hit   = hit_cnt_q;
   assign bus.stat_miss  = miss_q;
   assign bus.stat_evict = evict_q;
   assign bus.stat_wb    = wb_q;
`else
   assign bus.stat_acc   = '0;
   assign bus.stat_rd    = '0;
   assign bus.stat_wr    = '0;
   assign bus.stat_hit   = '0;
   assign bus.stat_miss  = '0;
   assign bus.stat_evict = '0;
   assign bus.stat_wb    = '0;
`endif
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: randomized and directed checks of cache_tag_ctrl against a recency-list cache model.
module tb_cache_tag_ctrl;
   localparam int SETS = 4, WAYS = 2, LB = 16, AW = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0, checks = 0;

   cache_tag_if #(.ADDR_W(AW)) bus();
   cache_tag_ctrl #(.SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LB), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // Model: each set keeps its ways in recency order, front = most recent.
   bit          mv [SETS][WAYS];
   bit          md [SETS][WAYS];
   int unsigned mt [SETS][WAYS];
   int          lru[SETS][$];
   int unsigned m_acc, m_rd, m_wr, m_hit, m_miss, m_evict, m_wb;

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         lru[s].delete();
         for (int w = 0; w < WAYS; w++) begin
            mv[s][w] = 0;
            md[s][w] = 0;
            lru[s].push_back(w);
         end
      end
      {m_acc, m_rd, m_wr, m_hit, m_miss, m_evict, m_wb} = '0;
   endfunction

   function automatic void model_access(input bit rw, input logic [AW-1:0] a,
                                        output bit h, output bit ev, output bit wb, output logic [AW-1:0] wa);
      int s, w, pos;
      int unsigned t;
      s = int'((a / LB) % SETS);
      t = a / (LB * SETS);
      h = 0; ev = 0; wb = 0; wa = '0; w = -1;
      for (int i = 0; i < WAYS; i++)
         if (mv[s][i] && mt[s][i] == t) begin h = 1; w = i; end
      if (!h) begin
         for (int i = WAYS - 1; i >= 0; i--)
            if (!mv[s][i]) w = i;
         if (w < 0) w = lru[s][$];
         ev = mv[s][w];
         wb = ev && md[s][w];
         wa = AW'(mt[s][w] * (LB * SETS) + s * LB);
         mt[s][w] = t; mv[s][w] = 1; md[s][w] = rw;
      end else if (rw) md[s][w] = 1;
      pos = 0;
      foreach (lru[s][i]) if (lru[s][i] == w) pos = i;
      lru[s].delete(pos);
      lru[s].push_front(w);
      m_acc++;
      if (rw) m_wr++; else m_rd++;
      if (h) m_hit++; else m_miss++;
      if (ev) m_evict++;
      if (wb) m_wb++;
   endfunction

   task automatic do_req(input bit rw, input logic [AW-1:0] a, input string nm);
      bit h, ev, wb;
      logic [AW-1:0] wa;
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle: got %b want 1", nm, bus.req_ready); end
      bus.req_valid = 1; bus.req_rw = rw; bus.req_addr = a;
      @(negedge clk);
      bus.req_valid = 0;
      checks++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b00) begin
         errors++; $display("FAIL %s lookup_cycle: ready,valid got %b want 00", nm, {bus.req_ready, bus.resp_valid});
      end
      @(negedge clk);
      model_access(rw, a, h, ev, wb, wa);
      checks++;
      if ({bus.resp_valid, bus.resp_hit, bus.resp_evict, bus.resp_wb} !== {1'b1, h, ev, wb}) begin
         errors++;
         $display("FAIL %s resp addr=%h: valid,hit,evict,wb got %b want %b", nm, a,
                  {bus.resp_valid, bus.resp_hit, bus.resp_evict, bus.resp_wb}, {1'b1, h, ev, wb});
      end
      if (wb) begin
         checks++;
         if (bus.resp_wb_addr !== wa) begin errors++; $display("FAIL %s wb_addr: got %h want %h", nm, bus.resp_wb_addr, wa); end
      end
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
         errors++; $display("FAIL %s after_resp: ready,valid got %b want 10", nm, {bus.req_ready, bus.resp_valid});
      end
   endtask

   task automatic do_flush(input bit with_req, input logic [AW-1:0] ra, input int exp_nwb, input string nm);
      int s, w, nwb;
      bit d;
      logic [AW-1:0] wa;
      nwb = 0;
      bus.flush_start = 1; bus.req_valid = with_req; bus.req_rw = 0; bus.req_addr = ra;
      @(negedge clk);
      bus.flush_start = 0;
      for (int i = 0; i < SETS * WAYS; i++) begin
         s = i / WAYS; w = i % WAYS;
         d = mv[s][w] && md[s][w];
         wa = AW'(mt[s][w] * (LB * SETS) + s * LB);
         checks++;
         if ({bus.resp_valid, bus.resp_wb, bus.resp_hit, bus.resp_evict, bus.flush_done, bus.req_ready}
             !== {d, d, 1'b0, 1'b0, i == SETS * WAYS - 1, 1'b0}) begin
            errors++;
            $display("FAIL %s line %0d: valid,wb,hit,evict,done,ready got %b want %b", nm, i,
                     {bus.resp_valid, bus.resp_wb, bus.resp_hit, bus.resp_evict, bus.flush_done, bus.req_ready},
                     {d, d, 1'b0, 1'b0, i == SETS * WAYS - 1, 1'b0});
         end
         if (d) begin
            checks++;
            if (bus.resp_wb_addr !== wa) begin errors++; $display("FAIL %s line %0d wb_addr: got %h want %h", nm, i, bus.resp_wb_addr, wa); end
            m_wb++;
         end
         nwb += int'(bus.resp_wb);
         mv[s][w] = 0; md[s][w] = 0;
         @(negedge clk);
      end
      checks++;
      if ({bus.req_ready, bus.flush_done, bus.resp_valid} !== 3'b100) begin
         errors++; $display("FAIL %s after_flush: ready,done,valid got %b want 100", nm, {bus.req_ready, bus.flush_done, bus.resp_valid});
      end
      if (exp_nwb >= 0) begin
         checks++;
         if (nwb != exp_nwb) begin errors++; $display("FAIL %s wb_count: got %0d want %0d", nm, nwb, exp_nwb); end
      end
      bus.req_valid = 0;
   endtask

   task automatic test_stats(input string nm);
      logic [31:0] got[7], exp[7];
      got = '{bus.stat_acc, bus.stat_rd, bus.stat_wr, bus.stat_hit, bus.stat_miss, bus.stat_evict, bus.stat_wb};
`ifdef CACHE_STATS_EN
      exp = '{m_acc, m_rd, m_wr, m_hit, m_miss, m_evict, m_wb};
`else
      exp = '{default: 32'd0};
`endif
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL %s stat[%0d]: got %0d want %0d", nm, i, got[i], exp[i]); end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_hit, bus.resp_evict, bus.resp_wb, bus.flush_done} !== 6'b100000) begin
         errors++; $display("FAIL reset outputs: got %b want 100000",
                            {bus.req_ready, bus.resp_valid, bus.resp_hit, bus.resp_evict, bus.resp_wb, bus.flush_done});
      end
      test_stats("reset");
   endtask

   task automatic test_lru_basic();
      do_req(0, 32'h000, "rd000_a");
      do_req(0, 32'h040, "rd040_a");
      do_req(0, 32'h000, "rd000_b");
      do_req(0, 32'h080, "rd080_evict");
      test_stats("basic");
   endtask

   task automatic test_lru_evict();
      do_req(1, 32'h000, "wr000_hit");
      do_req(0, 32'h040, "rd040_evict080");
      do_req(0, 32'h0C0, "rd0C0_wb000");
   endtask

   task automatic test_flush();
      do_req(1, 32'h010, "wr010");
      do_req(1, 32'h020, "wr020");
      do_flush(0, '0, 2, "flush");
      do_req(0, 32'h010, "rd010_after_flush");
   endtask

   task automatic test_flush_priority();
      do_flush(1, 32'h054, -1, "flush_prio");
      do_req(0, 32'h054, "req_after_flush");
   endtask

   task automatic test_reset_mid();
      bus.req_valid = 1; bus.req_rw = 1; bus.req_addr = 32'h000;
      @(negedge clk);
      bus.req_valid = 0;
      reset = 1;
      #1;
      checks++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
         errors++; $display("FAIL reset_mid abort: ready,valid got %b want 10", {bus.req_ready, bus.resp_valid});
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid no_resp: got %b want 0", bus.resp_valid); end
      reset = 0;
      model_reset();
      test_stats("reset_mid");
      do_req(0, 32'h000, "rd000_after_reset");
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 24) == 0) do_flush(0, '0, -1, "rand_flush");
         else begin
            a = AW'($urandom_range(0, 5) * (LB * SETS) + $urandom_range(0, SETS - 1) * LB + $urandom_range(0, LB - 1));
            do_req(1'($urandom_range(0, 1)), a, "rand");
         end
      end
      do_flush(0, '0, -1, "final_flush");
      test_stats("final");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 0; bus.req_rw = 0; bus.req_addr = '0; bus.flush_start = 0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 0;
      test_reset();
      test_lru_basic();
      test_lru_evict();
      test_flush();
      test_flush_priority();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Parametrised N-way set-associative cache tag/state controller with true-LRU replacement, write-back/write-allocate policy and a line-by-line flush engine. It is the cycle-accurate successor to the team's behavioural cache statistics model. It sits between the trace-driven request source and the (modelled) next-level memory. It decides hit/miss, picks victims, and reports evictions and write-backs over a valid/ready request and pulse response interface.

## Interface
- SETS, 1024: sets per way; power of two, ≥2.
- WAYS, 4: associativity; power of two, ≥2.
- LINE_BYTES, 64: line size in bytes; power of two, 4..256.
- ADDR_W, 32: request address width.
- Derived widths: OFFSET_W=$clog2(LINE_BYTES), INDEX_W=$clog2(SETS), TAG_W=ADDR_W-INDEX_W-OFFSET_W. Any illegal parameter is a $fatal at elaboration.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller in IDLE and able to accept.
- req_rw  in  1  0 = read, 1 = write.
- req_addr  in  ADDR_W  byte address.
- flush_start  in  1  begin full-cache flush; sampled only in IDLE.
- flush_done  out  1  one-cycle pulse when the flush completes.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_hit  out  1  lookup hit; 0 for flush responses.
- resp_evict  out  1  a valid victim line was replaced.
- resp_wb  out  1  the victim or flushed line was dirty and must be written back.
- resp_wb_addr  out  ADDR_W  {victim_tag, index, OFFSET_W'0}; valid when resp_wb=1.
- stat_acc, stat_rd, stat_wr, stat_hit, stat_miss, stat_evict, stat_wb  out  32 each  statistics counters.

## Operation
- Per-line state: tag[TAG_W], valid, dirty, age[$clog2(WAYS)]. Tag storage is not reset.
- Reset clears all valid and dirty bits and sets age[way]=way in every set.
- Index = req_addr[OFFSET_W+:INDEX_W]. Tag = req_addr[ADDR_W-1:OFFSET_W+INDEX_W].
- FSM states: IDLE → LOOKUP → RESP → IDLE for requests; IDLE → FLUSH → IDLE for flush.
- IDLE:
  - req_ready=1.
  - On flush_start go to FLUSH; flush has priority over req_valid in the same cycle, and the request is not accepted.
  - Else on req_valid, register rw/addr and go to LOOKUP.
- LOOKUP:
  - Hit means a valid way has a matching tag. At most one way may match; multiple matches are an assertion error.
  - On a miss, the victim is the lowest-index invalid way; if none is invalid, the victim is the way with age=WAYS-1.
- RESP:
  - Update arrays and pulse resp_valid.
  - Hit: set dirty if write.
  - Miss: write the tag, valid=1, dirty=rw. resp_evict=victim valid. resp_wb=victim valid&dirty.
- LRU update on the touched way w (hit or fill), with old age a:
  - Every way in the set with age<a increments.
  - Way w gets age 0.
  - Ages stay a permutation of 0..WAYS-1.
- FLUSH:
  - A counter walks set 0..SETS-1, and within each set way 0..WAYS-1, one line per cycle.
  - Each valid&dirty line produces resp_valid=1, resp_wb=1, resp_hit=0, resp_evict=0, with its address.
  - Every line ends with valid=0 and dirty=0; ages are untouched.
  - After the last line, pulse flush_done with the final step and return to IDLE.
- Reset mid-request or mid-flush aborts: the FSM goes to IDLE and the array state resets as above.

## Timing
- Request accepted at edge N (req_valid&req_ready). resp_valid is high in cycle N+2, and the arrays are updated at edge N+2.
- req_ready deasserts at N+1 and reasserts at N+3, giving 1 request per 3 cycles.
- Flush of SETS×WAYS lines takes SETS×WAYS cycles. flush_done is coincident with the last line's cycle.
- Reset values: req_ready=1, resp_*=0, flush_done=0, all stat_*=0.
- Counters saturate at 2^32-1 (no wrap).

## Configuration
- CACHE_STATS_EN defined:
  - stat_* counters are implemented and update at the RESP edge.
  - acc, rd/wr, hit/miss and evict/wb are updated per resp_* flags.
  - Flush write-backs also increment stat_wb.
- CACHE_STATS_EN undefined: the counter logic is removed and all stat_* ports are tied to 0.

## Test plan
Parameters for the scenarios below: SETS=4, WAYS=2, LINE_BYTES=16. Set 0 = addresses 0x000, 0x040, 0x080, 0x0C0.
- Read 0x000, read 0x040, read 0x000, read 0x080 → resp_hit 0,0,1,0. Fourth response has resp_evict=1, resp_wb=0 (0x040 was LRU).
- Continue: write 0x000 (hit), read 0x040, read 0x0C0 → 0x040 evicts 0x080 clean; 0x0C0 evicts 0x000 with resp_wb=1, resp_wb_addr=0x000.
- Write 0x010, 0x020, then flush_start → exactly 2 resp_wb pulses (addresses 0x010, 0x020), flush_done after 8 cycles; re-read 0x010 → miss, resp_evict=0.
- flush_start and req_valid in the same IDLE cycle → flush runs, req_ready=0 until flush_done+1; request accepted afterwards.
- Assert reset during LOOKUP after write 0x000 → no resp_valid, stats=0, next read 0x000 misses.
- With CACHE_STATS_EN, the first bullet's sequence → stat_acc=4, stat_rd=4, stat_hit=1, stat_miss=3, stat_evict=1, stat_wb=0; without the macro, all zero.
